// File: rtl/dac_wave_gen_if.sv
// ---------------------------------------------------------------------------
// dac_wave_gen_if
//   Sample stream between the waveform generator and the SPI DAC transmitter.
//   A code moves across on every cycle where sample_valid and sample_ready
//   are both high.
//
//   sample_valid  generator -> transmitter   sample_data holds a code
//   sample_data   generator -> transmitter   DAC code, WIDTH bits
//   sample_ready  transmitter -> generator   transmitter can take a code
//
//   master : the generator side (drives valid/data)
//   slave  : the transmitter side (drives ready)
// ---------------------------------------------------------------------------
interface dac_wave_gen_if #(
    parameter int WIDTH = 16
);
    logic             sample_valid;
    logic             sample_ready;
    logic [WIDTH-1:0] sample_data;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/dac_wave_gen.sv
// ---------------------------------------------------------------------------
// dac_wave_gen
//   Programmable DAC code generator: sawtooth up, sawtooth down, triangle or
//   hold, with a programmable step and inclusive min/max limits. Each code is
//   offered over a valid/ready stream, so the waveform only advances when the
//   SPI transmitter consumes a sample.
//
//   clk, reset     clock; asynchronous active-high reset
//   enable         run request (level)
//   mode           00 saw-up, 01 saw-down, 10 triangle, 11 hold
//   step           code increment per accepted sample
//   min_val        lower code limit, inclusive
//   max_val        upper code limit, inclusive
//   load/load_val  one-cycle request to preset the code
//   smp            sample stream (master side)
//   wrap           one-cycle pulse after a fire that wrapped or turned around
//   dir            triangle direction, 1 = up
//   cfg_err        high while min_val > max_val
// ---------------------------------------------------------------------------
module dac_wave_gen #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    dac_wave_gen_if.master    smp,
    output logic              wrap,
    output logic              dir,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] code;
        logic             wrap;
        logic             dir;
    } next_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic             apply;
    logic             fire;
    logic [WIDTH-1:0] load_code;
    next_t            nc;

    function automatic logic [WIDTH-1:0] clamp_code(
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Limit comparisons use one extra bit so c+step and min+step can never
    // wrap around silently.
    function automatic next_t next_code(
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi,
        input logic [1:0]       m,
        input logic             d
    );
        logic [WIDTH:0] up;
        logic [WIDTH:0] lo_s;
        next_t          r;
        up     = {1'b0, c}  + {1'b0, s};
        lo_s   = {1'b0, lo} + {1'b0, s};
        r.code = c;
        r.wrap = 1'b0;
        r.dir  = d;
        case (m)
            2'b00: begin
                if (up > {1'b0, hi}) begin
                    r.code = lo;
                    r.wrap = 1'b1;
                end else begin
                    r.code = up[WIDTH-1:0];
                end
            end
            2'b01: begin
                if ({1'b0, c} < lo_s) begin
                    r.code = hi;
                    r.wrap = 1'b1;
                end else begin
                    r.code = c - s;
                end
            end
            2'b10: begin
                if (d) begin
                    if (up >= {1'b0, hi}) begin
                        r.code = hi;
                        r.dir  = 1'b0;
                        r.wrap = (c != hi);
                    end else begin
                        r.code = up[WIDTH-1:0];
                    end
                end else begin
                    if ({1'b0, c} <= lo_s) begin
                        r.code = lo;
                        r.dir  = 1'b1;
                        r.wrap = (c != lo);
                    end else begin
                        r.code = c - s;
                    end
                end
            end
            default: ;
        endcase
        // A zero step leaves the code parked, so there is no event to flag.
        if (s == '0)
            r.wrap = 1'b0;
        return r;
    endfunction

    assign cfg_err          = (min_val > max_val);
    assign smp.sample_valid = (state_q == RUN);
    assign smp.sample_data  = data_q;
    assign wrap             = wrap_q;
    assign dir              = dir_q;
    assign fire             = smp.sample_valid & smp.sample_ready;
    assign load_code        = clamp_code(load_q, min_val, max_val);
    assign nc               = next_code(data_q, step, min_val, max_val, mode_q, dir_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= 2'b00;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            pend_q  <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        apply   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    data_d = load_code;
                    apply  = 1'b1;
                end
                if (enable && !cfg_err)
                    state_d = PRIME;
            end
            PRIME: begin
                mode_d = mode;
                dir_d  = 1'b1;
                if (pend_q) begin
                    data_d = load_code;
                    apply  = 1'b1;
                end else if (mode == 2'b01) begin
                    data_d = max_val;
                end else begin
                    data_d = min_val;
                end
                state_d = RUN;
            end
            RUN: begin
                // Nothing moves while the transmitter stalls; the offered
                // code stays on the bus until it is taken.
                if (fire) begin
                    mode_d = mode;
                    if (pend_q) begin
                        data_d = load_code;
                        apply  = 1'b1;
                    end else begin
                        data_d = nc.code;
                        dir_d  = nc.dir;
                        wrap_d = nc.wrap;
                    end
                    if (!enable || cfg_err)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A load arriving in the same cycle as an apply is kept for later.
        pend_d = load | (pend_q & ~apply);
        load_d = load ? load_val : load_q;
    end

endmodule

// File: tb/tb_dac_wave_gen.sv
// ---------------------------------------------------------------------------
// tb_dac_wave_gen
//   Directed bench for dac_wave_gen. Stimulus pushes the expected code
//   sequence into a queue; a separate monitor pops one entry per accepted
//   sample, checks the code, the registered wrap pulse that follows it, and
//   that stalled samples stay put.
// ---------------------------------------------------------------------------
module tb_dac_wave_gen;

    typedef struct {
        logic [15:0] data;
        logic        w;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] step;
    logic [15:0] min_val;
    logic [15:0] max_val;
    logic        load;
    logic [15:0] load_val;
    logic        wrap;
    logic        dir;
    logic        cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    dac_wave_gen_if #(.WIDTH(16)) sif ();

    dac_wave_gen #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .step     (step),
        .min_val  (min_val),
        .max_val  (max_val),
        .load     (load),
        .load_val (load_val),
        .smp      (sif.master),
        .wrap     (wrap),
        .dir      (dir),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic expect_code(input logic [15:0] d, input logic w);
        exp_t e;
        e.data = d;
        e.w    = w;
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept exactly n samples, then drop ready. Called and returns at
    // posedge+1. With rnd set, ready is randomised to create stalls.
    task automatic pull(input int n, input bit rnd);
        int got;
        int guard;
        got   = 0;
        guard = 0;
        sif.sample_ready = 1'b1;
        while (got < n && guard < 400) begin
            @(negedge clk);
            if (sif.sample_valid && sif.sample_ready)
                got++;
            @(posedge clk);
            #1;
            guard++;
            if (got < n)
                sif.sample_ready = rnd ? 1'(($urandom_range(0, 1))) : 1'b1;
        end
        sif.sample_ready = 1'b0;
        chk("pull_count", got, n);
    endtask

    // Scoreboard monitor
    initial begin : monitor
        logic        exp_wrap;
        logic        prev_stall;
        logic [15:0] prev_data;
        exp_t        it;
        exp_wrap   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_wrap   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                n_cmp++;
                if (wrap !== exp_wrap) begin
                    n_err++;
                    $display("FAIL wrap: got %b expected %b at %0t", wrap, exp_wrap, $time);
                end
                if (prev_stall) begin
                    n_cmp++;
                    if (sif.sample_valid !== 1'b1 || sif.sample_data !== prev_data) begin
                        n_err++;
                        $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h at %0t",
                                 sif.sample_valid, sif.sample_data, prev_data, $time);
                    end
                end
                exp_wrap = 1'b0;
                if (sif.sample_valid && sif.sample_ready) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_sample: got %h expected none at %0t", sif.sample_data, $time);
                    end else begin
                        it = sb.pop_front();
                        if (sif.sample_data !== it.data) begin
                            n_err++;
                            $display("FAIL sample: got %h expected %h at %0t", sif.sample_data, it.data, $time);
                        end
                        exp_wrap = it.w;
                    end
                end
                prev_stall = sif.sample_valid && !sif.sample_ready;
                prev_data  = sif.sample_data;
            end
        end
    end

    initial begin : stim
        reset            = 1'b1;
        enable           = 1'b0;
        mode             = 2'b00;
        step             = 16'h4000;
        min_val          = 16'h0000;
        max_val          = 16'hFFFF;
        load             = 1'b0;
        load_val         = 16'h0000;
        sif.sample_ready = 1'b0;
        cycles(3);
        chk("rst_valid", 32'(sif.sample_valid), 0);
        chk("rst_data", 32'(sif.sample_data), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_dir", 32'(dir), 1);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        reset = 1'b0;
        cycles(1);

        // Saw-up over the full range: wrap after 0xC000, no 17-bit overflow
        enable = 1'b1;
        expect_code(16'h0000, 0); expect_code(16'h4000, 0);
        expect_code(16'h8000, 0); expect_code(16'hC000, 1);
        expect_code(16'h0000, 0); expect_code(16'h4000, 0);
        expect_code(16'h8000, 0); expect_code(16'hC000, 1);
        pull(8, 0);
        enable = 1'b0;
        expect_code(16'h0000, 0);
        pull(1, 0);
        cycles(1);
        chk("saw_up_idle", 32'(sif.sample_valid), 0);

        // Triangle 10..20 step 4
        mode = 2'b10; min_val = 16'd10; max_val = 16'd20; step = 16'd4;
        enable = 1'b1;
        expect_code(16'd10, 0); expect_code(16'd14, 0); expect_code(16'd18, 1);
        pull(3, 0);
        chk("tri_dir_down", 32'(dir), 0);
        expect_code(16'd20, 0); expect_code(16'd16, 0); expect_code(16'd12, 1);
        pull(3, 0);
        chk("tri_dir_up", 32'(dir), 1);
        expect_code(16'd10, 0); expect_code(16'd14, 0);
        pull(2, 0);
        enable = 1'b0;
        expect_code(16'd18, 1);
        pull(1, 0);
        cycles(1);
        chk("tri_idle", 32'(sif.sample_valid), 0);

        // Saw-down 0x100..0x1FF step 0x80 with random back-pressure
        mode = 2'b01; min_val = 16'h0100; max_val = 16'h01FF; step = 16'h0080;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_code(16'h01FF, 0);
            expect_code(16'h017F, 1);
        end
        pull(6, 1);
        // Drop enable while stalled: the sample is still delivered once
        enable = 1'b0;
        cycles(3);
        chk("stall_valid_held", 32'(sif.sample_valid), 1);
        chk("stall_data_held", 32'(sif.sample_data), 32'h01FF);
        expect_code(16'h01FF, 0);
        pull(1, 0);
        cycles(1);
        chk("drop_enable_idle", 32'(sif.sample_valid), 0);

        // Load with enable rise wins at PRIME; stalled load waits for fire
        mode = 2'b11; min_val = 16'h0000; max_val = 16'hFFFF; step = 16'h0000;
        enable = 1'b1; load = 1'b1; load_val = 16'h0040;
        cycles(1);
        load = 1'b0;
        cycles(3);
        chk("load_prime_valid", 32'(sif.sample_valid), 1);
        chk("load_prime_data", 32'(sif.sample_data), 32'h0040);
        max_val = 16'h8000; load = 1'b1; load_val = 16'hFFFF;
        cycles(1);
        load = 1'b0;
        cycles(2);
        chk("load_stalled_data", 32'(sif.sample_data), 32'h0040);
        expect_code(16'h0040, 0);
        pull(1, 0);
        chk("load_clamped", 32'(sif.sample_data), 32'h8000);
        enable = 1'b0;
        expect_code(16'h8000, 0);
        pull(1, 0);

        // min > max: cfg_err, IDLE is held
        min_val = 16'h0200; max_val = 16'h0100;
        #1;
        chk("cfg_err_set", 32'(cfg_err), 1);
        enable = 1'b1;
        cycles(5);
        chk("cfg_err_idle", 32'(sif.sample_valid), 0);
        enable = 1'b0;
        min_val = 16'h0000; max_val = 16'hFFFF;
        #1;
        chk("cfg_err_clear", 32'(cfg_err), 0);
        cycles(1);

        // Reset mid-handshake with 0x1234 on the bus
        enable = 1'b1; load = 1'b1; load_val = 16'h1234;
        cycles(1);
        load = 1'b0;
        cycles(3);
        chk("pre_rst_data", 32'(sif.sample_data), 32'h1234);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_rst_valid", 32'(sif.sample_valid), 0);
        chk("async_rst_data", 32'(sif.sample_data), 0);
        cycles(2);
        reset = 1'b0;
        mode = 2'b00; min_val = 16'h0300; max_val = 16'h03FF; step = 16'h0010;
        enable = 1'b1;
        expect_code(16'h0300, 0); expect_code(16'h0310, 0);
        pull(2, 0);
        enable = 1'b0;
        expect_code(16'h0320, 0);
        pull(1, 0);
        cycles(3);
        chk("final_idle", 32'(sif.sample_valid), 0);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
